// File: rtl/nexys2_regs_pkg.sv
// Shared constants, register layout and 7-segment decode for the Nexys 2 I/O block.
package nexys2_regs_pkg;

   // Byte offsets within the block; only address bits [4:2] reach the decoder.
   localparam logic [4:0] OFS_SSEG     = 5'h00;
   localparam logic [4:0] OFS_SW       = 5'h04;
   localparam logic [4:0] OFS_BTN      = 5'h08;
   localparam logic [4:0] OFS_LED      = 5'h0C;
   localparam logic [4:0] OFS_BTN_EDGE = 5'h10;

   // SSEG register contents: decimal points above the four hex digits.
   typedef struct packed {
      logic [3:0]  dp;
      logic [15:0] digits;
   } sseg_reg_t;

   // Hex nibble to active-high segments {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
      logic [6:0] w_seg;
      case (i_hex)
         4'h0: w_seg = 7'h3F;
         4'h1: w_seg = 7'h06;
         4'h2: w_seg = 7'h5B;
         4'h3: w_seg = 7'h4F;
         4'h4: w_seg = 7'h66;
         4'h5: w_seg = 7'h6D;
         4'h6: w_seg = 7'h7D;
         4'h7: w_seg = 7'h07;
         4'h8: w_seg = 7'h7F;
         4'h9: w_seg = 7'h6F;
         4'hA: w_seg = 7'h77;
         4'hB: w_seg = 7'h7C;
         4'hC: w_seg = 7'h39;
         4'hD: w_seg = 7'h5E;
         4'hE: w_seg = 7'h79;
         default: w_seg = 7'h71;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/nexys2_regs_sseg_mux.sv
// Multiplexed 4-digit 7-segment driver: free-running refresh counter, digit select, registered
// active-low anode and cathode outputs.
module nexys2_regs_sseg_mux
   import nexys2_regs_pkg::*;
#(
   parameter int unsigned SSEG_DIV_WIDTH = 16
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  sseg_reg_t i_sseg,
   output logic [3:0] o_an,
   output logic [7:0] o_k
);

   logic [SSEG_DIV_WIDTH-1:0] r_cnt;
   logic [1:0]                w_digit;
   logic [3:0]                w_nib;
   logic                      w_dp;
   logic [3:0]                w_an_d;

   assign w_digit = r_cnt[SSEG_DIV_WIDTH-1 -: 2];

   // Pick the nibble, decimal point and anode for the digit currently being refreshed.
   always_comb begin
      w_nib  = i_sseg.digits[3:0];
      w_dp   = i_sseg.dp[0];
      w_an_d = 4'b1111;
      w_an_d[w_digit] = 1'b0;
      case (w_digit)
         2'd1: begin
            w_nib = i_sseg.digits[7:4];
            w_dp  = i_sseg.dp[1];
         end
         2'd2: begin
            w_nib = i_sseg.digits[11:8];
            w_dp  = i_sseg.dp[2];
         end
         2'd3: begin
            w_nib = i_sseg.digits[15:12];
            w_dp  = i_sseg.dp[3];
         end
         default: ;
      endcase
   end

   // Advance the refresh counter and register the active-low display outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         o_an  <= 4'hF;
         o_k   <= 8'hFF;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         o_an  <= w_an_d;
         o_k   <= {~w_dp, ~hex_to_seg(w_nib)};
      end
   end

endmodule

// File: rtl/nexys2_regs.sv
// Wishbone register block for Nexys 2 board I/O: 7-segment display, LEDs, synchronised switches
// and buttons, and sticky button-press flags.
module nexys2_regs
   import nexys2_regs_pkg::*;
#(
   parameter int unsigned SSEG_DIV_WIDTH = 16
) (
   input  logic        CLK,
   input  logic        RST_SYNC,
   input  logic        WB_CYC_IN,
   input  logic        WB_STB_IN,
   input  logic [31:0] WB_ADR_IN,
   input  logic [3:0]  WB_SEL_IN,
   input  logic        WB_WE_IN,
   output logic        WB_ACK_OUT,
   output logic [31:0] WB_DAT_RD_OUT,
   input  logic [31:0] WB_DAT_WR_IN,
   input  logic [7:0]  SW_IN,
   input  logic [3:0]  BTN_IN,
   output logic [7:0]  LED_OUT,
   output logic [3:0]  SSEG_AN_OUT,
   output logic [7:0]  SSEG_K_OUT
);

   logic [7:0]  r_sw_s1, r_sw_s2;
   logic [3:0]  r_btn_s1, r_btn_s2, r_btn_s3;
   sseg_reg_t   r_sseg, w_sseg_d;
   logic [7:0]  r_led, w_led_d;
   logic [3:0]  r_edge, w_edge_d, w_clr;
   logic        r_ack;
   logic [31:0] r_rd, w_rd_d;
   logic        w_access;
   logic [4:0]  w_ofs;
   logic        w_unused_bits;

   // Holding ack for one cycle blocks a back-to-back access, so held STB repeats every 2nd cycle.
   assign w_access = WB_CYC_IN & WB_STB_IN & ~r_ack;
   assign w_ofs    = {WB_ADR_IN[4:2], 2'b00};

   assign w_unused_bits = ^{WB_ADR_IN[31:5], WB_ADR_IN[1:0], WB_SEL_IN[3], WB_DAT_WR_IN[31:20]};

   // Two-flop synchronisers on the asynchronous pins, plus a third button stage for edge detect.
   always_ff @(posedge CLK) begin
      if (RST_SYNC) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_btn_s1 <= '0;
         r_btn_s2 <= '0;
         r_btn_s3 <= '0;
      end else begin
         r_sw_s1  <= SW_IN;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= BTN_IN;
         r_btn_s2 <= r_btn_s1;
         r_btn_s3 <= r_btn_s2;
      end
   end

   // Decode the bus access into register next-state and read data.
   always_comb begin
      w_sseg_d = r_sseg;
      w_led_d  = r_led;
      w_clr    = '0;
      w_rd_d   = '0;
      if (w_access && WB_WE_IN) begin
         case (w_ofs)
            OFS_SSEG: begin
               if (WB_SEL_IN[0]) w_sseg_d.digits[7:0]  = WB_DAT_WR_IN[7:0];
               if (WB_SEL_IN[1]) w_sseg_d.digits[15:8] = WB_DAT_WR_IN[15:8];
               if (WB_SEL_IN[2]) w_sseg_d.dp           = WB_DAT_WR_IN[19:16];
            end
            OFS_LED:      if (WB_SEL_IN[0]) w_led_d = WB_DAT_WR_IN[7:0];
            OFS_BTN_EDGE: if (WB_SEL_IN[0]) w_clr   = WB_DAT_WR_IN[3:0];
            default: ;
         endcase
      end else if (w_access) begin
         case (w_ofs)
            OFS_SSEG:     w_rd_d = {12'h000, r_sseg};
            OFS_SW:       w_rd_d = {24'h00_0000, r_sw_s2};
            OFS_BTN:      w_rd_d = {28'h000_0000, r_btn_s2};
            OFS_LED:      w_rd_d = {24'h00_0000, r_led};
            OFS_BTN_EDGE: w_rd_d = {28'h000_0000, r_edge};
            default:      w_rd_d = '0;
         endcase
      end
      // A new rising edge beats a simultaneous clear.
      w_edge_d = (r_edge & ~w_clr) | (r_btn_s2 & ~r_btn_s3);
   end

   // Register state, single-cycle ack and read data; reset discards any in-flight access.
   always_ff @(posedge CLK) begin
      if (RST_SYNC) begin
         r_sseg <= '0;
         r_led  <= '0;
         r_edge <= '0;
         r_ack  <= 1'b0;
         r_rd   <= '0;
      end else begin
         r_sseg <= w_sseg_d;
         r_led  <= w_led_d;
         r_edge <= w_edge_d;
         r_ack  <= w_access;
         r_rd   <= w_rd_d;
      end
   end

   assign WB_ACK_OUT    = r_ack;
   assign WB_DAT_RD_OUT = r_rd;
   assign LED_OUT       = r_led;

   nexys2_regs_sseg_mux #(
      .SSEG_DIV_WIDTH(SSEG_DIV_WIDTH)
   ) u_sseg_mux (
      .i_clk  (CLK),
      .i_rst  (RST_SYNC),
      .i_sseg (r_sseg),
      .o_an   (SSEG_AN_OUT),
      .o_k    (SSEG_K_OUT)
   );

endmodule
